// File: rtl/accum_alu_seq_if.sv
// Request/result bundle between the operand/opcode sequencer (master)
// and the accumulator ALU core (slave).
interface accum_alu_seq_if #(
  parameter int K = 4
);
  logic [K-1:0]   A;
  logic [3:0]     opcode;
  logic           valid;
  logic           ready;
  logic [2*K-1:0] C;
  logic           busy;
  logic           done;
  logic [1:0]     error;

  modport master (
    output A, opcode, valid,
    input  ready, C, busy, done, error
  );

  modport slave (
    input  A, opcode, valid,
    output ready, C, busy, done, error
  );
endinterface

// File: rtl/accum_alu_seq.sv
// Accumulator ALU: K-bit operand A against B = C[K-1:0], 2K-bit accumulator.
// Single-cycle ops commit at accept; MULT (shift-add) and DIV/MOD (restoring)
// iterate for K cycles behind the valid/ready handshake. Error flags are sticky.
module accum_alu_seq #(
  parameter int K  = 4,
  parameter int CW = $clog2(K) + 1
) (
  input logic            clk,
  input logic            rst,
  accum_alu_seq_if.slave bus
);
  localparam int SW = $clog2(K);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_reg, state_next;
  logic [2*K-1:0]   c_reg, c_next;
  logic [1:0]       err_reg, err_next;
  logic             done_reg, done_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2*K-1:0]   mcand_reg, mcand_next;
  logic [K-1:0]     mplier_reg, mplier_next;
  logic [2*K-1:0]   prod_reg, prod_next;
  logic [K-1:0]     dvsr_reg, dvsr_next;
  logic [K-1:0]     rem_reg, rem_next;
  logic [K-1:0]     quo_reg, quo_next;
  logic             mod_reg, mod_next;

  logic [K-1:0]     b_op;
  logic             accept;
  logic [K-1:0]     add_res, sub_res;
  logic             add_ovf, sub_ovf;
  logic [SW-1:0]    shamt;
  logic [2*K-1:0]   mul_sum;
  logic [K:0]       div_trial, div_diff;
  logic [K-1:0]     div_rem, div_quo;

  assign b_op    = c_reg[K-1:0];
  assign accept  = bus.valid && (state_reg == IDLE);
  assign add_res = b_op + bus.A;
  assign sub_res = b_op - bus.A;
  // Overflow: result sign differs from B when the operation could not change it legally.
  assign add_ovf = (b_op[K-1] == bus.A[K-1]) && (add_res[K-1] != b_op[K-1]);
  assign sub_ovf = (b_op[K-1] != bus.A[K-1]) && (sub_res[K-1] != b_op[K-1]);
  assign shamt   = bus.A[SW-1:0];

  // One partial product per cycle: multiplicand shifts left, multiplier shifts right.
  assign mul_sum = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Restoring division step: bring in the next dividend bit, keep the
  // difference only if it did not borrow.
  assign div_trial = {rem_reg, quo_reg[K-1]};
  assign div_diff  = div_trial - {1'b0, dvsr_reg};
  assign div_rem   = div_diff[K] ? div_trial[K-1:0] : div_diff[K-1:0];
  assign div_quo   = {quo_reg[K-2:0], ~div_diff[K]};

  assign bus.ready = (state_reg == IDLE);
  assign bus.busy  = (state_reg != IDLE);
  assign bus.C     = c_reg;
  assign bus.done  = done_reg;
  assign bus.error = err_reg;

  // Next-state, datapath and result selection.
  always_comb begin
    state_next  = state_reg;
    c_next      = c_reg;
    err_next    = err_reg;
    done_next   = 1'b0;
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    prod_next   = prod_reg;
    dvsr_next   = dvsr_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    mod_next    = mod_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          done_next = 1'b1;
          case (bus.opcode)
            4'b0001: begin
              c_next   = '0;
              err_next = 2'b00;
            end
            4'b0010: begin
              c_next      = {{K{add_res[K-1]}}, add_res};
              err_next[0] = err_reg[0] | add_ovf;
            end
            4'b0011: begin
              c_next      = {{K{sub_res[K-1]}}, sub_res};
              err_next[0] = err_reg[0] | sub_ovf;
            end
            4'b0100: begin
              done_next   = 1'b0;
              mcand_next  = {{K{1'b0}}, bus.A};
              mplier_next = b_op;
              prod_next   = '0;
              cnt_next    = CW'(K);
              state_next  = MUL;
            end
            4'b0101, 4'b0110: begin
              if (bus.A == '0) begin
                err_next[1] = 1'b1;
              end else begin
                done_next  = 1'b0;
                dvsr_next  = bus.A;
                quo_next   = b_op;
                rem_next   = '0;
                mod_next   = bus.opcode[1];
                cnt_next   = CW'(K);
                state_next = DIV;
              end
            end
            4'b0111: c_next = {{K{1'b0}}, b_op & bus.A};
            4'b1000: c_next = {{K{1'b0}}, b_op | bus.A};
            4'b1001: c_next = {{K{1'b0}}, ~b_op};
            4'b1010: c_next = {{K{1'b0}}, b_op ^ bus.A};
            4'b1011: c_next = {{K{1'b0}}, ~(b_op & bus.A)};
            4'b1100: c_next = {{K{1'b0}}, ~(b_op | bus.A)};
            4'b1101: c_next = {{K{1'b0}}, ~(b_op ^ bus.A)};
            4'b1110: c_next = {{K{1'b0}}, b_op << shamt};
            4'b1111: c_next = {{K{1'b0}}, b_op >> shamt};
            default: c_next = c_reg;
          endcase
        end
      end
      MUL: begin
        prod_next   = mul_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          c_next     = mul_sum;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      DIV: begin
        rem_next = div_rem;
        quo_next = div_quo;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          c_next     = mod_reg ? {{K{1'b0}}, div_rem} : {{K{1'b0}}, div_quo};
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      c_reg      <= '0;
      err_reg    <= 2'b00;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      dvsr_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      mod_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      c_reg      <= c_next;
      err_reg    <= err_next;
      done_reg   <= done_next;
      cnt_reg    <= cnt_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      prod_reg   <= prod_next;
      dvsr_reg   <= dvsr_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      mod_reg    <= mod_next;
    end
  end
endmodule

// File: doc/accum_alu_seq.md
Name: accum_alu_seq

Overview:
- Parametrised successor of the 4-bit accumulator ALU: K-bit operand A, 2K-bit accumulator, same 16-entry opcode map.
- Shift opcodes 1110/1111 are now implemented.
- MULT/DIV/MOD are multi-cycle iterative datapaths behind a valid/ready handshake.
- Error flags are registered and sticky.
- Sits as the arithmetic core fed by the operand/opcode sequencer; C drives the display/readback path.

Parameters:
- K, 4, operand width; accumulator width is 2K; K >= 2, power of two.
- CW, $clog2(K)+1, width of the iteration counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- A  in  K  operand A, sampled on accept
- opcode  in  4  operation, sampled on accept
- valid  in  1  request; an op is accepted on an edge where valid && ready
- ready  out  1  high when IDLE and able to accept
- C  out  2K  accumulator register, direct register output
- busy  out  1  high while a multi-cycle op iterates
- done  out  1  one-cycle pulse when any accepted op has committed its result
- error  out  2  [1] divide-by-zero, [0] signed add/sub overflow; sticky

Behaviour:
- Operand B = C[K-1:0] for every op.
- Reset (rst=1 at an edge):
  - C=0, error=00, done=0, state=IDLE, counter=0.
  - ready=1 and busy=0 from the following cycle.
  - rst overrides everything, including an op in flight; the partial result is discarded.
- Opcode map and result widths (result replaces C):
  - 0000 NOP: C unchanged.
  - 0001 CLEAR: C=0, error=00.
  - 0010 ADD, 0011 SUB:
    - K-bit B+A or B-A, sign-extended to 2K.
    - error[0] |= signed overflow, i.e. operand signs equal (ADD) or differ (SUB), and the result sign differs from B.
  - 0100 MULT: unsigned K x K, 2K-bit product, never sets error.
  - 0101 DIV, 0110 MOD: unsigned B/A and B%A, zero-extended to 2K.
  - 0111..1101 AND, OR, NOT(B), XOR, NAND, NOR, XNOR: K-bit, zero-extended.
  - 1110 SHL, 1111 SHR: logical shift of B by A mod K; K-bit result, zero-extended.
- Timing, single-cycle ops (0000-0011, 0111-1111):
  - Accepted at edge n; C and error are updated at edge n.
  - done=1 for the cycle after edge n.
  - ready stays 1.
- State machine: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted 0100.
  - IDLE -> DIV on accepted 0101/0110 when A != 0.
- MUL state (shift-add):
  - Latch A and B at accept.
  - One partial-product step per cycle; counter counts K down to 1.
  - At edge n+K: write the product to C, return to IDLE, done=1 for the next cycle.
- DIV state (restoring divider):
  - One quotient bit per cycle, MSB first.
  - At edge n+K: write the quotient (DIV) or remainder (MOD) to C, return to IDLE, done pulse.
- busy=1 and ready=0 for the K cycles after accept; valid is ignored while busy.
- Divide by zero (0101/0110 with A=0):
  - Handled as single-cycle: no state change; C unchanged; error[1] set.
  - done pulses.
- Sticky errors:
  - error bits only set.
  - Cleared only by rst or CLEAR.
  - A CLEAR in the same op as a fault is impossible, since an op has one opcode.
- The accumulator is written only at accept (single-cycle ops) or at iteration end (MUL/DIV); A/opcode changes mid-iteration have no effect.
- done and the next accept may coincide: a new op may be accepted on the same edge that ends done's high cycle.

Test Plan (K=4):
- rst; CLEAR; ADD A=2; ADD A=2 -> C=0x04 after the second accept edge, error=00, done pulses twice.
- CLEAR; ADD 3; SUB 5 -> C=0xFE, error=00.
- CLEAR; ADD 5; MULT 3 -> ready=0/busy=1 for exactly 4 cycles, C=0x05 until the 4th edge then 0x0F; a valid ADD 1 held during busy is ignored.
- CLEAR; ADD 7; DIV 3 -> C=0x02 after 4 cycles; repeat with MOD 3 -> C=0x01.
- Error stickiness:
  - CLEAR; ADD 7; DIV 0 -> C stays 0x07, error=10.
  - Then ADD 7 -> C=0xFE (1110 sign-extended), error=11.
  - NOP -> error still 11.
  - CLEAR -> C=0x00, error=00.
- Shifts and reset abort:
  - CLEAR; ADD 0b1010; SHL A=1 -> C=0x04; SHR A=6 -> C=0x01 (shift 2).
  - MULT accepted, rst asserted on the 2nd busy cycle -> C=0, ready=1, busy=0, no done pulse.
